// File: rtl/pistorm_bus_engine.sv
// Queued 68000 bus-cycle engine: command FIFO, S1-S7 bus sequencer with 6800 VPA/VMA/E
// support, per-cycle DTACK timeout and one response per command.
module pistorm_bus_engine #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned E_PERIOD = 10,
    parameter int unsigned E_HIGH   = 4
) (
    input  logic              PI_CLK,
    input  logic              PI_RESET_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic              cmd_byte,
    input  logic [2:0]        cmd_fc,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              busy,
    input  logic              M68K_CLK,
    output logic [ADDR_W-2:0] M68K_A,
    output logic [15:0]       M68K_D_O,
    input  logic [15:0]       M68K_D_I,
    output logic              M68K_D_OE,
    output logic [2:0]        M68K_FC,
    output logic              M68K_AS_n,
    output logic              M68K_UDS_n,
    output logic              M68K_LDS_n,
    output logic              M68K_RW,
    input  logic              M68K_DTACK_n,
    input  logic              M68K_BERR_n,
    input  logic              M68K_VPA_n,
    input  logic              M68K_BGACK_n,
    output logic              M68K_E,
    output logic              M68K_VMA_n,
    output logic              M68K_BUS_OE
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned E_W   = $clog2(E_PERIOD);
    localparam int unsigned T_W   = $clog2(TIMEOUT + 2);

    typedef struct packed {
        logic              rw;
        logic              is_byte;
        logic [2:0]        fc;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
    } cmd_t;

    typedef enum logic [2:0] {StIdle, StS1, StS2, StS3, StS4, StS5, StS6, StS7} state_t;

    state_t           state_q, state_d;
    logic [2:0]       c7m_q;
    logic [3:0]       in_s1, in_s2;
    logic [15:0]      d_s1, d_s2;
    logic [E_W-1:0]   e_cnt_q;
    logic [T_W-1:0]   tcnt_q;
    cmd_t             mem [DEPTH];
    cmd_t             wk_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             vma_q, rsp_valid_q;
    logic [15:0]      rdata_q;
    logic [1:0]       err_q, s3_err;
    logic             c7m_rise, c7m_fall, push, pop, start, s3_done;
    logic             dtack_s, berr_s, vpa_s, bgack_s;
    logic [1:0]       lane_n;

    assign c7m_rise = c7m_q[1] & ~c7m_q[2];
    assign c7m_fall = ~c7m_q[1] & c7m_q[2];
    assign {bgack_s, vpa_s, berr_s, dtack_s} = in_s2;

    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign start     = (state_q == StIdle) && (count_q != '0) && !rsp_valid_q && bgack_s;
    assign pop       = start;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign busy        = (count_q != '0) || (state_q != StIdle) || rsp_valid_q;
    assign M68K_E      = (e_cnt_q >= E_W'(E_PERIOD - E_HIGH));
    assign M68K_VMA_n  = vma_q;
    assign M68K_A      = wk_q.addr[ADDR_W-1:1];
    assign M68K_D_O    = wk_q.wdata;
    assign M68K_BUS_OE = !((state_q == StIdle) && !bgack_s);
    assign lane_n      = !wk_q.is_byte ? 2'b00 : (wk_q.addr[0] ? 2'b10 : 2'b01);

    // S3 exit decision; BERR outranks DTACK, the timeout is the last resort.
    always_comb begin
        s3_done = 1'b1;
        s3_err  = 2'b00;
        if (!berr_s) begin
            s3_err = 2'b01;
        end else if (!dtack_s) begin
            s3_err = 2'b00;
        end else if (!vma_q && (e_cnt_q == E_W'(E_PERIOD - 2))) begin
            s3_err = 2'b00;
        end else if ((TIMEOUT != 0) && (tcnt_q == T_W'(TIMEOUT))) begin
            s3_err = 2'b10;
        end else begin
            s3_done = 1'b0;
        end
    end

    always_ff @(posedge PI_CLK or negedge PI_RESET_n) begin
        if (!PI_RESET_n) state_q <= StIdle;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start)                state_d = StS1;
            StS1:   if (c7m_rise)             state_d = StS2;
            StS2:   if (c7m_fall)             state_d = StS3;
            StS3:   if (c7m_rise && s3_done)  state_d = StS4;
            StS4:   if (c7m_fall)             state_d = StS5;
            StS5:   if (c7m_rise)             state_d = StS6;
            StS6:   if (c7m_fall)             state_d = StS7;
            StS7:                             state_d = StIdle;
        endcase
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        M68K_AS_n  = 1'b1;
        M68K_UDS_n = 1'b1;
        M68K_LDS_n = 1'b1;
        M68K_RW    = 1'b1;
        M68K_FC    = 3'b111;
        M68K_D_OE  = 1'b0;
        case (state_q)
            StS1: M68K_FC = wk_q.fc;
            StS2: begin
                M68K_FC   = wk_q.fc;
                M68K_AS_n = 1'b0;
                if (wk_q.rw) begin
                    {M68K_UDS_n, M68K_LDS_n} = lane_n;
                end else begin
                    M68K_RW   = 1'b0;
                    M68K_D_OE = 1'b1;
                end
            end
            StS3, StS4, StS5, StS6: begin
                M68K_FC                  = wk_q.fc;
                M68K_AS_n                = 1'b0;
                {M68K_UDS_n, M68K_LDS_n} = lane_n;
                M68K_RW                  = wk_q.rw;
                M68K_D_OE                = !wk_q.rw;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PI_CLK) begin
        if (push) mem[wr_ptr_q] <= '{cmd_rw, cmd_byte, cmd_fc, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge PI_CLK or negedge PI_RESET_n) begin
        if (!PI_RESET_n) begin
            c7m_q       <= '0;
            in_s1       <= '1;
            in_s2       <= '1;
            d_s1        <= '0;
            d_s2        <= '0;
            e_cnt_q     <= '0;
            tcnt_q      <= '0;
            wk_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            vma_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= '0;
        end else begin
            c7m_q <= {c7m_q[1:0], M68K_CLK};
            in_s1 <= {M68K_BGACK_n, M68K_VPA_n, M68K_BERR_n, M68K_DTACK_n};
            in_s2 <= in_s1;
            d_s1  <= M68K_D_I;
            d_s2  <= d_s1;
            if (c7m_fall) begin
                e_cnt_q <= (e_cnt_q == E_W'(E_PERIOD - 1)) ? '0 : e_cnt_q + E_W'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                wk_q     <= mem[rd_ptr_q];
            end
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
            if (state_q == StS2) tcnt_q <= '0;
            if ((state_q == StS3) && c7m_rise) begin
                if (s3_done) begin
                    err_q <= s3_err;
                end else begin
                    tcnt_q <= tcnt_q + T_W'(1);
                    if (!vpa_s && (e_cnt_q == E_W'(2))) vma_q <= 1'b0;
                end
            end
            if ((state_q == StS6) && c7m_fall) begin
                rdata_q <= (wk_q.rw && (err_q == 2'b00)) ? d_s2 : 16'h0000;
                vma_q   <= 1'b1;
            end
            if (state_q == StS7)                rsp_valid_q <= 1'b1;
            else if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pistorm_bus_engine.sv
// Bench for pistorm_bus_engine: a small bus-slave model plus a response scoreboard.
`timescale 1ns/100ps
module tb_pistorm_bus_engine;

    localparam int ADDR_W = 24;

    logic              pi_clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              m68k_clk = 1'b0;
    logic              cmd_valid = 1'b0, cmd_rw = 1'b0, cmd_byte = 1'b0;
    logic [2:0]        cmd_fc = 3'b000;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [15:0]       cmd_wdata = '0;
    logic              rsp_ready = 1'b0;
    logic              cmd_ready, rsp_valid, busy;
    logic [15:0]       rsp_rdata;
    logic [1:0]        rsp_err;
    logic [ADDR_W-2:0] m_a;
    logic [15:0]       d_o, d_i;
    logic              d_oe, as_n, uds_n, lds_n, rw, e, vma_n, bus_oe;
    logic [2:0]        fc;
    logic              dtack_n, berr_n, vpa_n;
    logic              bgack_n = 1'b1;

    logic              dtack_en = 1'b0, berr_en = 1'b0, vpa_en = 1'b0, fixed_en = 1'b0;
    logic [15:0]       fixed_d = 16'h0000;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_d_q[$];
    logic [1:0]  exp_e_q[$];
    realtime     as_fall_q[$];
    realtime     t_efall = 0, t_erise = 0, t_vmafall = 0, t_asrise = 0;

    always #2.5 pi_clk = ~pi_clk;
    initial begin
        #1;
        forever #70 m68k_clk = ~m68k_clk;
    end

    // Slave answers while AS is low; read data derives from the address.
    assign dtack_n = dtack_en ? as_n : 1'b1;
    assign berr_n  = berr_en ? as_n : 1'b1;
    assign vpa_n   = vpa_en ? as_n : 1'b1;
    assign d_i     = fixed_en ? fixed_d : (m_a[15:0] ^ 16'hC3A5);

    always @(negedge as_n) as_fall_q.push_back($realtime);
    always @(posedge as_n) t_asrise = $realtime;
    always @(negedge e)    t_efall = $realtime;
    always @(posedge e)    t_erise = $realtime;
    always @(negedge vma_n) t_vmafall = $realtime;

    pistorm_bus_engine #(
        .ADDR_W(ADDR_W), .DEPTH(4), .TIMEOUT(16), .E_PERIOD(10), .E_HIGH(4)
    ) dut (
        .PI_CLK(pi_clk), .PI_RESET_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_byte(cmd_byte),
        .cmd_fc(cmd_fc), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .M68K_CLK(m68k_clk), .M68K_A(m_a), .M68K_D_O(d_o), .M68K_D_I(d_i),
        .M68K_D_OE(d_oe), .M68K_FC(fc), .M68K_AS_n(as_n), .M68K_UDS_n(uds_n),
        .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_DTACK_n(dtack_n), .M68K_BERR_n(berr_n),
        .M68K_VPA_n(vpa_n), .M68K_BGACK_n(bgack_n), .M68K_E(e), .M68K_VMA_n(vma_n),
        .M68K_BUS_OE(bus_oe)
    );

    function automatic logic [15:0] slave_data(input logic [ADDR_W-1:0] addr);
        return addr[16:1] ^ 16'hC3A5;
    endfunction

    function automatic real absr(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic push_cmd(input logic r, input logic b, input logic [2:0] f,
                            input logic [ADDR_W-1:0] a, input logic [15:0] wd,
                            input logic [15:0] ed, input logic [1:0] ee, output bit acc);
        @(negedge pi_clk);
        cmd_rw = r; cmd_byte = b; cmd_fc = f; cmd_addr = a; cmd_wdata = wd;
        cmd_valid = 1'b1;
        acc = cmd_ready;
        @(posedge pi_clk);
        #1 cmd_valid = 1'b0;
        if (acc) begin
            exp_d_q.push_back(ed);
            exp_e_q.push_back(ee);
        end
    endtask

    task automatic wait_as(input logic lvl, output bit ok);
        int n = 0;
        @(negedge pi_clk);
        while (as_n !== lvl && n < 4000) begin
            @(negedge pi_clk);
            n++;
        end
        ok = (as_n === lvl);
    endtask

    task automatic pop_rsp(input string name);
        int n = 0;
        logic [15:0] ed;
        logic [1:0]  ee;
        @(negedge pi_clk);
        while (!rsp_valid && n < 20000) begin
            @(negedge pi_clk);
            n++;
        end
        if (rsp_valid !== 1'b1 || exp_d_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: rsp_valid=%b queued=%0d, required a response", name, rsp_valid,
                     exp_d_q.size());
            return;
        end
        ed = exp_d_q.pop_front();
        ee = exp_e_q.pop_front();
        total++;
        if (rsp_rdata !== ed) begin
            bad++;
            $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, ed);
        end
        total++;
        if (rsp_err !== ee) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, rsp_err, ee);
        end
        rsp_ready = 1'b1;
        @(posedge pi_clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #20;
        total++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy} !== {1'b1, 1'b0, 16'h0, 2'b00, 1'b0})
        begin
            bad++;
            $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h err=%b busy=%b", cmd_ready,
                     rsp_valid, rsp_rdata, rsp_err, busy);
        end
        total++;
        if ({as_n, uds_n, lds_n, rw, fc, d_oe, vma_n, e, bus_oe} !== 11'b1111_111_0101) begin
            bad++;
            $display("FAIL reset_bus: as=%b uds=%b lds=%b rw=%b fc=%b oe=%b vma=%b e=%b busoe=%b",
                     as_n, uds_n, lds_n, rw, fc, d_oe, vma_n, e, bus_oe);
        end
        @(negedge pi_clk);
        rst_n = 1'b1;
        repeat (4) @(negedge pi_clk);
    endtask

    task automatic test_word_read();
        bit acc, ok;
        real d;
        fixed_en = 1'b1; fixed_d = 16'h1234; dtack_en = 1'b1;
        as_fall_q.delete();
        push_cmd(1'b1, 1'b0, 3'b101, 24'hBFE001, 16'h0, 16'h1234, 2'b00, acc);
        push_cmd(1'b1, 1'b0, 3'b101, 24'hBFE001, 16'h0, 16'h1234, 2'b00, acc);
        wait_as(1'b0, ok);
        total++;
        if (!ok || {uds_n, lds_n, rw, fc} !== 6'b00_1_101) begin
            bad++;
            $display("FAIL word_strobes: as=%b uds=%b lds=%b rw=%b fc=%b want 0 0 0 1 101",
                     as_n, uds_n, lds_n, rw, fc);
        end
        total++;
        if (m_a !== 23'h5FF000) begin
            bad++;
            $display("FAIL word_addr: got %h want 5ff000", m_a);
        end
        pop_rsp("word_read_1");
        pop_rsp("word_read_2");
        // Back-to-back cycles must be whole c7m periods, at least 3 and at most 4.
        total++;
        d = (as_fall_q.size() >= 2) ? as_fall_q[1] - as_fall_q[0] : 0.0;
        if (as_fall_q.size() < 2 || d < 419.9 || d > 560.1 ||
            absr(d - 140.0 * $rtoi(d / 140.0 + 0.5)) > 0.1) begin
            bad++;
            $display("FAIL as_to_as: got %0.1f ns want 420..560 in 140 ns steps", d);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_byte_write();
        bit acc, ok;
        int n = 0;
        dtack_en = 1'b1;
        push_cmd(1'b0, 1'b1, 3'b001, 24'h000003, 16'h00AB, 16'h0000, 2'b00, acc);
        wait_as(1'b0, ok);
        total++;
        if (!ok || {rw, d_oe, uds_n, lds_n} !== 4'b0111) begin
            bad++;
            $display("FAIL write_s2: rw=%b oe=%b uds=%b lds=%b want 0 1 1 1", rw, d_oe, uds_n,
                     lds_n);
        end
        while (lds_n !== 1'b0 && n < 4000) begin
            @(negedge pi_clk);
            n++;
        end
        total++;
        if ({lds_n, uds_n, rw, d_oe, d_o} !== {4'b0101, 16'h00AB}) begin
            bad++;
            $display("FAIL write_lane: lds=%b uds=%b rw=%b oe=%b d_o=%h want 0 1 0 1 00ab",
                     lds_n, uds_n, rw, d_oe, d_o);
        end
        pop_rsp("byte_write");
    endtask

    task automatic test_vpa();
        bit acc, ok;
        int n = 0;
        realtime r0;
        dtack_en = 1'b0; vpa_en = 1'b1; fixed_en = 1'b1; fixed_d = 16'hBEEF;
        push_cmd(1'b1, 1'b0, 3'b101, 24'h000100, 16'h0, 16'hBEEF, 2'b00, acc);
        while (vma_n !== 1'b0 && n < 8000) begin
            @(negedge pi_clk);
            n++;
        end
        total++;
        if (vma_n !== 1'b0 || e !== 1'b0 || absr(t_vmafall - t_efall - 350.0) > 0.1) begin
            bad++;
            $display("FAIL vma_assert: vma=%b e=%b efall_to_vma=%0.1f want 0 0 350", vma_n, e,
                     t_vmafall - t_efall);
        end
        wait_as(1'b1, ok);
        total++;
        if (!ok || vma_n !== 1'b1 || absr(t_asrise - t_vmafall - 1050.0) > 0.1) begin
            bad++;
            $display("FAIL vpa_end: vma=%b vma_to_as_release=%0.1f want 1 1050", vma_n,
                     t_asrise - t_vmafall);
        end
        pop_rsp("vpa_read");
        vpa_en = 1'b0; fixed_en = 1'b0;
        n = 0;
        while (e !== 1'b0 && n < 1000) begin @(negedge pi_clk); n++; end
        while (e !== 1'b1 && n < 1000) begin @(negedge pi_clk); n++; end
        r0 = t_erise;
        while (e !== 1'b0 && n < 1000) begin @(negedge pi_clk); n++; end
        while (e !== 1'b1 && n < 1000) begin @(negedge pi_clk); n++; end
        total++;
        if (absr(t_efall - r0 - 560.0) > 0.1) begin
            bad++;
            $display("FAIL e_high: got %0.1f ns want 560", t_efall - r0);
        end
        total++;
        if (absr(t_erise - r0 - 1400.0) > 0.1) begin
            bad++;
            $display("FAIL e_period: got %0.1f ns want 1400", t_erise - r0);
        end
    endtask

    task automatic test_timeout_berr();
        bit acc;
        real d;
        dtack_en = 1'b0;
        as_fall_q.delete();
        push_cmd(1'b1, 1'b0, 3'b110, 24'h000200, 16'h0, 16'h0000, 2'b10, acc);
        pop_rsp("timeout");
        total++;
        d = (as_fall_q.size() >= 1) ? t_asrise - as_fall_q[0] : 0.0;
        if (d < 16.0 * 140.0 || d > 19.0 * 140.0) begin
            bad++;
            $display("FAIL timeout_len: AS low %0.1f ns want 2240..2660", d);
        end
        dtack_en = 1'b1; berr_en = 1'b1;
        push_cmd(1'b1, 1'b0, 3'b110, 24'h000204, 16'h0, 16'h0000, 2'b01, acc);
        pop_rsp("berr");
        berr_en = 1'b0;
    endtask

    task automatic test_bgack();
        bit acc;
        bit saw_as = 1'b0;
        dtack_en = 1'b1; bgack_n = 1'b0;
        repeat (4) @(negedge pi_clk);
        total++;
        if (bus_oe !== 1'b0) begin
            bad++;
            $display("FAIL bgack_oe: got %b want 0", bus_oe);
        end
        push_cmd(1'b1, 1'b0, 3'b101, 24'h000400, 16'h0, slave_data(24'h000400), 2'b00, acc);
        repeat (84) begin
            @(negedge pi_clk);
            if (as_n !== 1'b1) saw_as = 1'b1;
        end
        total++;
        if (saw_as || busy !== 1'b1 || bus_oe !== 1'b0) begin
            bad++;
            $display("FAIL bgack_hold: saw_as=%b busy=%b busoe=%b want 0 1 0", saw_as, busy,
                     bus_oe);
        end
        bgack_n = 1'b1;
        pop_rsp("bgack_release");
        total++;
        if (bus_oe !== 1'b1) begin
            bad++;
            $display("FAIL bgack_oe_back: got %b want 1", bus_oe);
        end
    endtask

    task automatic test_fifo();
        bit acc;
        int n_acc = 0;
        int n = 0;
        logic [ADDR_W-1:0] a;
        dtack_en = 1'b1; bgack_n = 1'b0;
        repeat (4) @(negedge pi_clk);
        for (int i = 0; i < 5; i++) begin
            a = 24'h001000 + ADDR_W'(i * 2);
            push_cmd(1'b1, 1'b0, 3'b101, a, 16'h0, slave_data(a), 2'b00, acc);
            if (acc) n_acc++;
        end
        total++;
        if (n_acc != 4 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL fifo_full: accepted=%0d ready=%b want 4 0", n_acc, cmd_ready);
        end
        bgack_n = 1'b1;
        while (rsp_valid !== 1'b1 && n < 4000) begin @(negedge pi_clk); n++; end
        repeat (56) @(negedge pi_clk);
        total++;
        if (rsp_valid !== 1'b1 || as_n !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL fifo_stall: valid=%b as=%b ready=%b want 1 1 1", rsp_valid, as_n,
                     cmd_ready);
        end
        a = 24'h001008;
        push_cmd(1'b1, 1'b0, 3'b101, a, 16'h0, slave_data(a), 2'b00, acc);
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL fifo_refill: accepted=%b want 1", acc);
        end
        for (int i = 0; i < 5; i++) pop_rsp($sformatf("fifo_drain_%0d", i));
    endtask

    task automatic test_reset_mid();
        bit acc, ok;
        dtack_en = 1'b0;
        push_cmd(1'b1, 1'b0, 3'b101, 24'h000300, 16'h0, 16'h0, 2'b10, acc);
        push_cmd(1'b1, 1'b0, 3'b101, 24'h000302, 16'h0, 16'h0, 2'b10, acc);
        wait_as(1'b0, ok);
        repeat (20) @(negedge pi_clk);
        #1 rst_n = 1'b0;
        #0.5;
        total++;
        if (!ok || {as_n, uds_n, lds_n, busy, rsp_valid, cmd_ready} !== 6'b111_001) begin
            bad++;
            $display("FAIL reset_mid: ok=%b as=%b uds=%b lds=%b busy=%b valid=%b ready=%b",
                     ok, as_n, uds_n, lds_n, busy, rsp_valid, cmd_ready);
        end
        exp_d_q.delete();
        exp_e_q.delete();
        @(negedge pi_clk);
        rst_n = 1'b1;
        dtack_en = 1'b1;
        push_cmd(1'b1, 1'b0, 3'b101, 24'h000304, 16'h0, slave_data(24'h000304), 2'b00, acc);
        pop_rsp("after_reset");
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_vpa();
        test_timeout_berr();
        test_bgack();
        test_fifo();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
